axi4_burst_master: RTL

Single-outstanding AXI4 burst master that turns simple command/stream requests into INCR write and read bursts toward the `axi4` memory-mapped slave. It sits directly upstream of that slave, driving its AW/W/B/AR/R channels, and gives test or system logic a simplified front end. It runs one transaction at a time and reports completion with a single-cycle done pulse carrying the response.

---
 rtl/axi4_master_pkg.sv | 28 ++
 rtl/axi4_burst_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master_pkg.sv
// Shared types and helpers for axi4_burst_master: FSM state encoding,
// AXI response codes, and the AxSIZE / response-merge helper functions.
package axi4_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5,
        ST_DONE = 3'd6
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // AxSIZE code for a full-width beat: log2(bytes per beat).
    function automatic logic [2:0] size_of(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // Worst-of merge for accumulated responses (higher code is worse).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst master with a simple command / stream
// front end. One write (AW->W->B) or read (AR->R) burst at a time; completion
// is signalled by a one-cycle done pulse carrying the burst response.
// Optional build macro AXI4M_4K_CHECK_EN: commands that are misaligned or
// would cross a 4 KB boundary are rejected with SLVERR instead of issued.
//
// Handshake rule for every channel here: a transfer happens on the rising
// ACLK edge where VALID and READY are both high; a source that raises VALID
// keeps it and its payload stable until that edge, and READY may depend on
// VALID but VALID never waits on READY.
module axi4_burst_master
    import axi4_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    // command front end
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // write stream
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // read stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // AXI4 write address
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI4 write data
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI4 write response
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI4 read address
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI4 read data
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,
    // debug view of the FSM
    output state_e                dbg_state
);

    localparam logic [2:0] AXI_SIZE = size_of(DATA_WIDTH);
    localparam int         BYTES    = DATA_WIDTH / 8;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_acc;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  bready_q;
    logic                  done_q;
    logic [1:0]            done_resp_q;

    logic                  in_w;
    logic                  in_r;
    logic                  w_hs;
    logic                  r_hs;
    logic                  at_last;
    logic                  len_err;
    logic [1:0]            r_acc_next;
    logic                  cmd_bad;

    assign in_w    = (state_q == ST_W);
    assign in_r    = (state_q == ST_R);
    assign at_last = (beat_cnt == len_q);

    // Front end and address channels come straight from state / registers.
    assign cmd_ready = (state_q == ST_IDLE);
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = AXI_SIZE;
    assign AWVALID   = awvalid_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = AXI_SIZE;
    assign ARVALID   = arvalid_q;
    assign BREADY    = bready_q;
    assign done      = done_q;
    assign done_resp = done_resp_q;
    assign dbg_state = state_q;

    // Write beats pass straight through, but only while in the W state so no
    // data can leak onto W before the AW handshake has completed.
    assign WVALID   = in_w & wr_valid;
    assign wr_ready = in_w & WREADY;
    assign WDATA    = in_w ? wr_data : '0;
    assign WLAST    = in_w & at_last;
    assign w_hs     = WVALID & WREADY;

    // Read beats mirror the R channel with no added latency.
    assign rd_valid = in_r & RVALID;
    assign RREADY   = in_r & rd_ready;
    assign rd_data  = in_r ? RDATA : '0;
    assign rd_last  = in_r & RLAST;
    assign r_hs     = rd_valid & rd_ready;

    // A burst whose RLAST disagrees with the requested length is an error,
    // but we still wait for the slave's RLAST before completing.
    assign len_err    = RLAST ? !at_last : at_last;
    assign r_acc_next = len_err ? RESP_SLVERR : resp_max(resp_acc, RRESP);

`ifdef AXI4M_4K_CHECK_EN
    logic [31:0] addr_ext;
    logic [31:0] burst_end;
    assign addr_ext  = 32'(cmd_addr);
    assign burst_end = (addr_ext & 32'h0000_0FFF)
                     + ((32'(cmd_len) + 32'd1) * 32'(BYTES)) - 32'd1;
    assign cmd_bad   = (burst_end > 32'h0000_0FFF)
                     || ((addr_ext & 32'(BYTES - 1)) != 32'd0);
`else
    assign cmd_bad = 1'b0;
`endif

    // Transaction FSM: sequences one burst and owns all registered outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            resp_acc    <= RESP_OKAY;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= RESP_OKAY;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        beat_cnt <= '0;
                        resp_acc <= RESP_OKAY;
                        if (cmd_bad) begin
                            resp_acc    <= RESP_SLVERR;
                            done_q      <= 1'b1;
                            done_resp_q <= RESP_SLVERR;
                            state_q     <= ST_DONE;
                        end else if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state_q   <= ST_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_AW: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        state_q   <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (at_last) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (BVALID) begin
                        bready_q    <= 1'b0;
                        resp_acc    <= BRESP;
                        done_q      <= 1'b1;
                        done_resp_q <= BRESP;
                        state_q     <= ST_DONE;
                    end
                end
                ST_AR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        resp_acc <= r_acc_next;
                        if (RLAST) begin
                            done_q      <= 1'b1;
                            done_resp_q <= r_acc_next;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
